// File: rtl/pixel_adc_readout.sv
// Pixel ADC readout: follows the sequencer phase strobes, drives bias/ramp/DAC code,
// scans the pixel select during READ and queues captured values into a small FIFO.
module pixel_adc_readout #(
    parameter int N_PIX      = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = $clog2(N_PIX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              expose,
    input  logic              convert,
    input  logic              read,
    output logic              bias_en,
    output logic              ramp_en,
    output logic [DATA_W-1:0] dac_code,
    output logic [IDX_W-1:0]  pix_sel,
    input  logic [DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPOSE  = 2'd1,
        S_CONVERT = 2'd2,
        S_READ    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                bias_en_q, bias_en_d;
    logic                ramp_en_q, ramp_en_d;
    logic [DATA_W-1:0]   dac_code_q, dac_code_d;
    logic [IDX_W-1:0]    pix_sel_q, pix_sel_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic [IDX_W-1:0]    mem_idx_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                push_req_s;
    logic                push_ok_s;
    logic                pop_s;
    logic                last_s;
    logic                full_s;

    // Phase FSM, DAC ramp, pixel scan and FIFO bookkeeping (next-state logic)
    always_comb begin
        state_d      = state_q;
        bias_en_d    = 1'b0;
        ramp_en_d    = 1'b0;
        dac_code_d   = {DATA_W{1'b0}};
        pix_sel_d    = {IDX_W{1'b0}};
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        // erase also suppresses the capture, since the frame is being abandoned
        push_req_s   = (state_q == S_READ) && read && !erase;
        last_s       = push_req_s && (pix_sel_q == IDX_W'(N_PIX - 1));
        full_s       = (count_q == CNT_W'(FIFO_DEPTH));
        pop_s        = (count_q != {CNT_W{1'b0}}) && out_ready;
        push_ok_s    = push_req_s && (!full_s || pop_s);
        frame_done_d = last_s;
        overflow_d   = overflow_q || (push_req_s && !push_ok_s);

        if (erase) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (expose) state_d = S_EXPOSE;
                    else        state_d = S_IDLE;
                end
                S_EXPOSE: begin
                    if (convert) state_d = S_CONVERT;
                    else         state_d = S_EXPOSE;
                end
                S_CONVERT: begin
                    if (read) state_d = S_READ;
                    else      state_d = S_CONVERT;
                end
                S_READ: begin
                    if (!read || last_s) state_d = S_IDLE;
                    else                 state_d = S_READ;
                end
                default: state_d = S_IDLE;
            endcase
        end

        bias_en_d = (state_d == S_EXPOSE);
        ramp_en_d = (state_d == S_CONVERT);

        if ((state_d == S_CONVERT) && (state_q == S_CONVERT)) begin
            if (dac_code_q != {DATA_W{1'b1}}) dac_code_d = dac_code_q + DATA_W'(1);
            else                              dac_code_d = dac_code_q;
        end else begin
            dac_code_d = {DATA_W{1'b0}};
        end

        if ((state_d == S_READ) && (state_q == S_READ)) begin
            pix_sel_d = pix_sel_q + IDX_W'(1);
        end else begin
            pix_sel_d = {IDX_W{1'b0}};
        end

        if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        else           wr_ptr_d = wr_ptr_q;

        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else       rd_ptr_d = rd_ptr_q;

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bias_en_q    <= 1'b0;
            ramp_en_q    <= 1'b0;
            dac_code_q   <= {DATA_W{1'b0}};
            pix_sel_q    <= {IDX_W{1'b0}};
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            bias_en_q    <= bias_en_d;
            ramp_en_q    <= ramp_en_d;
            dac_code_q   <= dac_code_d;
            pix_sel_q    <= pix_sel_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; a full-and-popping write lands in the slot being vacated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= {DATA_W{1'b0}};
                mem_idx_q[i]  <= {IDX_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_data_q[wr_ptr_q] <= pix_data;
            mem_idx_q[wr_ptr_q]  <= pix_sel_q;
        end
    end

    assign bias_en    = bias_en_q;
    assign ramp_en    = ramp_en_q;
    assign dac_code   = dac_code_q;
    assign pix_sel    = pix_sel_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign out_valid  = (count_q != {CNT_W{1'b0}});
    assign out_data   = mem_data_q[rd_ptr_q];
    assign out_idx    = mem_idx_q[rd_ptr_q];

endmodule

// File: tb/tb_pixel_adc_readout.sv
// Directed bench for pixel_adc_readout (N_PIX=4, DATA_W=8, FIFO_DEPTH=4).
module tb_pixel_adc_readout;

    logic       clk = 1'b0;
    logic       reset, erase, expose, convert, read, out_ready;
    logic [7:0] pix_data, pix_base;
    logic       bias_en, ramp_en, out_valid, frame_done, overflow;
    logic [7:0] dac_code, out_data;
    logic [1:0] pix_sel, out_idx;

    int n_assert = 0;
    int n_fail   = 0;

    pixel_adc_readout #(.N_PIX(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .erase(erase), .expose(expose),
        .convert(convert), .read(read), .bias_en(bias_en), .ramp_en(ramp_en),
        .dac_code(dac_code), .pix_sel(pix_sel), .pix_data(pix_data),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // pixel array model: each pixel returns base + its index
    always_comb pix_data = pix_base + 8'(pix_sel);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_bias"}, 32'(bias_en), 32'd0);
        chk({tag, "_ramp"}, 32'(ramp_en), 32'd0);
        chk({tag, "_dac"}, 32'(dac_code), 32'd0);
        chk({tag, "_sel"}, 32'(pix_sel), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    // IDLE -> EXPOSE (1 cycle) -> CONVERT (n cycles), then READ entry edge
    task automatic to_read(input int n_conv);
        expose = 1'b1; cyc(); expose = 1'b0;
        convert = 1'b1; repeat (n_conv) cyc(); convert = 1'b0;
        read = 1'b1; cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; erase = 1'b0; expose = 1'b0; convert = 1'b0; read = 1'b0;
        out_ready = 1'b0; pix_base = 8'h10;
        cyc(); cyc();
        chk_idle_outs("reset");
        reset = 1'b0;
        cyc();

        // nominal frame
        out_ready = 1'b1;
        expose = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nom_bias_hi", 32'(bias_en), 32'd1);
            chk("nom_ramp_lo", 32'(ramp_en), 32'd0);
        end
        expose = 1'b0; convert = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            cyc();
            chk("nom_bias_lo", 32'(bias_en), 32'd0);
            chk("nom_ramp_hi", 32'(ramp_en), 32'd1);
            chk("nom_dac", 32'(dac_code), 32'(m - 1));
        end
        convert = 1'b0; read = 1'b1;
        cyc();
        chk("nom_rd_ramp", 32'(ramp_en), 32'd0);
        chk("nom_rd_dac", 32'(dac_code), 32'd0);
        chk("nom_rd_sel", 32'(pix_sel), 32'd0);
        chk("nom_rd_valid", 32'(out_valid), 32'd0);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("nom_valid", 32'(out_valid), 32'd1);
            chk("nom_idx", 32'(out_idx), 32'(j));
            chk("nom_data", 32'(out_data), 32'(8'h10 + j));
            chk("nom_sel", 32'(pix_sel), 32'((j + 1) % 4));
            chk("nom_fdone", 32'(frame_done), (j == 3) ? 32'd1 : 32'd0);
        end
        read = 1'b0;
        cyc();
        chk("nom_fdone_end", 32'(frame_done), 32'd0);
        chk("nom_empty", 32'(out_valid), 32'd0);
        chk("nom_ovf", 32'(overflow), 32'd0);

        // DAC saturation
        expose = 1'b1; cyc(); expose = 1'b0; convert = 1'b1;
        for (int m = 1; m <= 300; m++) begin
            cyc();
            if (m == 1 || m == 255 || m == 256 || m == 300)
                chk("sat_dac", 32'(dac_code), (m - 1 > 255) ? 32'd255 : 32'(m - 1));
        end
        convert = 1'b0; read = 1'b1;
        cyc();
        chk("sat_dac_clr", 32'(dac_code), 32'd0);
        repeat (3) cyc();
        cyc();
        chk("sat_fdone", 32'(frame_done), 32'd1);
        read = 1'b0;
        cyc();

        // backpressure over two frames
        out_ready = 1'b0; pix_base = 8'h20;
        to_read(2);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("bp_head_idx", 32'(out_idx), 32'd0);
            chk("bp_head_data", 32'(out_data), 32'h20);
            chk("bp_ovf_f1", 32'(overflow), 32'd0);
        end
        read = 1'b0; cyc();
        pix_base = 8'h30;
        to_read(2);
        cyc();
        chk("bp_ovf_f2", 32'(overflow), 32'd1);
        repeat (3) cyc();
        read = 1'b0; cyc();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_idx", 32'(out_idx), 32'(j));
            chk("bp_drain_data", 32'(out_data), 32'(8'h20 + j));
            cyc();
        end
        chk("bp_drain_empty", 32'(out_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(overflow), 32'd1);

        // async reset clears sticky overflow
        #2 reset = 1'b1; #1;
        chk("rst_ovf", 32'(overflow), 32'd0);
        cyc(); reset = 1'b0; cyc();

        // full FIFO with simultaneous pop
        out_ready = 1'b0; pix_base = 8'h40;
        to_read(2);
        repeat (4) cyc();
        read = 1'b0; cyc();
        pix_base = 8'h50;
        to_read(2);
        out_ready = 1'b1;
        cyc();
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_head_idx", 32'(out_idx), 32'd1);
        chk("fp_head_data", 32'(out_data), 32'h41);
        out_ready = 1'b0;
        cyc();
        chk("fp_still_full", 32'(overflow), 32'd1);
        read = 1'b0; cyc();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("fp_drain_idx", 32'(out_idx), (j == 3) ? 32'd0 : 32'(j + 1));
            chk("fp_drain_data", 32'(out_data), (j == 3) ? 32'h50 : 32'(8'h41 + j));
            cyc();
        end
        chk("fp_drain_empty", 32'(out_valid), 32'd0);

        // erase abort in CONVERT at dac_code 5
        #2 reset = 1'b1; cyc(); reset = 1'b0; cyc();
        expose = 1'b1; cyc(); expose = 1'b0; convert = 1'b1;
        repeat (6) cyc();
        chk("er_dac5", 32'(dac_code), 32'd5);
        erase = 1'b1; cyc(); erase = 1'b0; convert = 1'b0;
        chk("er_ramp", 32'(ramp_en), 32'd0);
        chk("er_dac", 32'(dac_code), 32'd0);
        read = 1'b1;
        repeat (3) cyc();
        chk("er_read_sel", 32'(pix_sel), 32'd0);
        chk("er_read_valid", 32'(out_valid), 32'd0);
        chk("er_read_bias", 32'(bias_en), 32'd0);
        read = 1'b0; expose = 1'b1; cyc(); expose = 1'b0;
        chk("er_expose", 32'(bias_en), 32'd1);

        // async reset in READ after two pushes
        convert = 1'b1; cyc(); convert = 1'b0;
        out_ready = 1'b0; read = 1'b1; cyc();
        cyc(); cyc();
        chk("ar_sel2", 32'(pix_sel), 32'd2);
        chk("ar_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1; #1;
        chk_idle_outs("ar");
        cyc(); reset = 1'b0;
        cyc();
        chk("ar_idle_sel", 32'(pix_sel), 32'd0);
        chk("ar_idle_valid", 32'(out_valid), 32'd0);
        read = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
